// File: rtl/threshold_pkg.sv
// ---------------------------------------------------------------------------
// threshold_pkg
// Shared types and helpers for the streaming threshold engine.
//   state_e   : frame sequencer states (IDLE, VSYNC, HSYNC, DATA, DONE)
//   mode_e    : output mode codes (binary, inverted binary, grey, RGB)
//   lane_lsb  : bit offset of a lane inside the packed {B,G,R} input beat
// ---------------------------------------------------------------------------
package threshold_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VSYNC = 3'd1,
        ST_HSYNC = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'd0,
        MODE_INV  = 2'd1,
        MODE_GREY = 2'd2,
        MODE_RGB  = 2'd3
    } mode_e;

    // Colour components carried per pixel.
    localparam int COMPONENTS = 3;

    // Lane k occupies bits [k*3*comp_width +: 3*comp_width]; R sits at the
    // returned offset, G and B follow at +comp_width and +2*comp_width.
    function automatic int lane_lsb(input int lane, input int comp_width);
        return lane * COMPONENTS * comp_width;
    endfunction

endpackage

// File: rtl/pixel_lane_threshold.sv
// ---------------------------------------------------------------------------
// pixel_lane_threshold
// One pixel lane, purely combinational: grey conversion (R+G+B)/3, then the
// mode multiplexer. Also reports whether the grey value is above threshold.
// Ports:
//   red_in/green_in/blue_in  in   DATA_WIDTH  input components
//   threshold                in   DATA_WIDTH  latched grey threshold
//   mode                     in   2           latched output mode (mode_e)
//   red_out/green_out/blue_out out DATA_WIDTH output components
//   white                    out  1           grey > threshold
// ---------------------------------------------------------------------------
module pixel_lane_threshold
    import threshold_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] red_in,
    input  logic [DATA_WIDTH-1:0] green_in,
    input  logic [DATA_WIDTH-1:0] blue_in,
    input  logic [DATA_WIDTH-1:0] threshold,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] red_out,
    output logic [DATA_WIDTH-1:0] green_out,
    output logic [DATA_WIDTH-1:0] blue_out,
    output logic                  white
);

    logic [DATA_WIDTH+1:0] sum;
    logic [DATA_WIDTH+1:0] quot;
    logic [DATA_WIDTH-1:0] grey;
    logic [DATA_WIDTH-1:0] bin;
    logic                  unused_quot_msbs;

    // Two extra bits hold the worst-case sum of three full-scale components.
    // The quotient of that sum by 3 never exceeds full scale, so its top two
    // bits are always zero and the low DATA_WIDTH bits are the grey value.
    always_comb begin
        sum  = {2'b00, red_in} + {2'b00, green_in} + {2'b00, blue_in};
        quot = sum / (DATA_WIDTH+2)'(3);
        grey = quot[DATA_WIDTH-1:0];
    end

    assign unused_quot_msbs = ^quot[DATA_WIDTH+1:DATA_WIDTH];

    // Strictly greater: a grey value equal to the threshold is black.
    assign white = (grey > threshold);
    assign bin   = {DATA_WIDTH{white}};

    always_comb begin
        red_out   = red_in;
        green_out = green_in;
        blue_out  = blue_in;
        case (mode)
            MODE_BIN: begin
                red_out   = bin;
                green_out = bin;
                blue_out  = bin;
            end
            MODE_INV: begin
                red_out   = ~bin;
                green_out = ~bin;
                blue_out  = ~bin;
            end
            MODE_GREY: begin
                red_out   = grey;
                green_out = grey;
                blue_out  = grey;
            end
            default: begin
                red_out   = red_in;
                green_out = green_in;
                blue_out  = blue_in;
            end
        endcase
    end

endmodule

// File: rtl/stream_threshold_engine.sv
// ---------------------------------------------------------------------------
// stream_threshold_engine
// Accepts a live RGB stream of LANES pixels per beat (valid/ready), converts
// each pixel to grey, applies the selected threshold/pass-through mode and
// emits the result one cycle later together with frame timing pulses.
//
// Optional feature: define STREAM_THRESHOLD_STATS_EN to add the white_count
// output, a per-frame count of pixels whose grey value exceeds the threshold.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               frame start request (only honoured in IDLE)
//   threshold, mode     latched when a start is accepted
//   in_valid/in_ready   input handshake; in_ready is high only in DATA
//   in_data             LANES x {B,G,R}, lane 0 / R in the LSBs
//   data_Red/Green/Blue registered per-lane output components
//   out_valid           output beat valid (horizontal_Pulse mirrors it)
//   vertical_Pulse      high while in VSYNC
//   busy                sequencer not idle
//   sig_done            one-cycle end-of-frame pulse
//   white_count         (STREAM_THRESHOLD_STATS_EN only) white pixel count
// ---------------------------------------------------------------------------
module stream_threshold_engine
    import threshold_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512,
    parameter int LANES        = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int START_DELAY  = 100,
    parameter int HSYNC_DELAY  = 160
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [DATA_WIDTH-1:0]           threshold,
    input  logic [1:0]                      mode,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*3*DATA_WIDTH-1:0]   in_data,
    output logic [LANES*DATA_WIDTH-1:0]     data_Red,
    output logic [LANES*DATA_WIDTH-1:0]     data_Green,
    output logic [LANES*DATA_WIDTH-1:0]     data_Blue,
    output logic                            out_valid,
    output logic                            vertical_Pulse,
    output logic                            horizontal_Pulse,
    output logic                            busy,
    output logic                            sig_done
`ifdef STREAM_THRESHOLD_STATS_EN
    ,
    output logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1)-1:0] white_count
`endif
);

    localparam int PIX_W     = LANES * DATA_WIDTH;
    localparam int COL_W     = $clog2(IMAGE_WIDTH + 1);
    localparam int ROW_W     = $clog2(IMAGE_HEIGHT + 1);
    localparam int MAX_DELAY = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
    localparam int DLY_W     = $clog2(MAX_DELAY + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - LANES);
    localparam logic [COL_W-1:0] COL_STEP = COL_W'(LANES);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [DLY_W-1:0] VS_LAST  = DLY_W'(START_DELAY - 1);
    localparam logic [DLY_W-1:0] HS_LAST  = DLY_W'(HSYNC_DELAY - 1);

    // Sequencer state and counters
    state_e            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DLY_W-1:0]  dly_q, dly_d;

    // Frame configuration latched on an accepted start
    logic [DATA_WIDTH-1:0] thr_q, thr_d;
    logic [1:0]            mode_q, mode_d;

    // Registered output beat
    logic [PIX_W-1:0] red_q, red_d;
    logic [PIX_W-1:0] green_q, green_d;
    logic [PIX_W-1:0] blue_q, blue_d;
    logic             out_valid_q, out_valid_d;

    // Combinational lane results
    logic [PIX_W-1:0] lane_red;
    logic [PIX_W-1:0] lane_green;
    logic [PIX_W-1:0] lane_blue;
    logic [LANES-1:0] lane_white;

    logic accept;
    logic start_ok;

    assign accept   = in_valid && in_ready;
    assign start_ok = start && (state_q == ST_IDLE);

    // ---------------------------------------------------------------- lanes
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            pixel_lane_threshold #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_lane (
                .red_in    (in_data[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
                .green_in  (in_data[lane_lsb(gi, DATA_WIDTH) + DATA_WIDTH +: DATA_WIDTH]),
                .blue_in   (in_data[lane_lsb(gi, DATA_WIDTH) + 2*DATA_WIDTH +: DATA_WIDTH]),
                .threshold (thr_q),
                .mode      (mode_q),
                .red_out   (lane_red[gi*DATA_WIDTH +: DATA_WIDTH]),
                .green_out (lane_green[gi*DATA_WIDTH +: DATA_WIDTH]),
                .blue_out  (lane_blue[gi*DATA_WIDTH +: DATA_WIDTH]),
                .white     (lane_white[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------ state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dly_q   <= dly_d;
        end
    end

    // ----------------------------------------------------- next-state logic
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dly_d   = dly_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_VSYNC;
                    col_d   = '0;
                    row_d   = '0;
                    dly_d   = '0;
                end
            end
            ST_VSYNC: begin
                if (dly_q == VS_LAST) begin
                    state_d = ST_HSYNC;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            ST_HSYNC: begin
                if (dly_q == HS_LAST) begin
                    state_d = ST_DATA;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            ST_DATA: begin
                // A stalled cycle (no accept) leaves every counter untouched.
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = ST_DONE;
                            row_d   = '0;
                        end else begin
                            state_d = ST_HSYNC;
                            row_d   = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_STEP;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // --------------------------------------------------------- output logic
    always_comb begin
        in_ready       = (state_q == ST_DATA);
        vertical_Pulse = (state_q == ST_VSYNC);
        busy           = (state_q != ST_IDLE);
        sig_done       = (state_q == ST_DONE);
    end

    // ------------------------------------------------------------ datapath
    // Output registers only load on an accepted beat, so the last beat stays
    // visible while out_valid is low.
    always_comb begin
        thr_d       = start_ok ? threshold : thr_q;
        mode_d      = start_ok ? mode : mode_q;
        red_d       = accept ? lane_red   : red_q;
        green_d     = accept ? lane_green : green_q;
        blue_d      = accept ? lane_blue  : blue_q;
        out_valid_d = accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thr_q       <= '0;
            mode_q      <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            thr_q       <= thr_d;
            mode_q      <= mode_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_Red         = red_q;
    assign data_Green       = green_q;
    assign data_Blue        = blue_q;
    assign out_valid        = out_valid_q;
    assign horizontal_Pulse = out_valid_q;

    // ---------------------------------------------------------- statistics
`ifdef STREAM_THRESHOLD_STATS_EN
    localparam int CNT_W = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT + 1);

    logic [CNT_W-1:0] white_count_q, white_count_d;
    logic [CNT_W-1:0] white_inc;

    // The white flag is independent of the mode, so the count is the same
    // whichever output format the frame uses.
    always_comb begin
        white_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            white_inc = white_inc + CNT_W'(lane_white[i]);
        end
        white_count_d = white_count_q;
        if (start_ok) begin
            white_count_d = '0;
        end else if (accept) begin
            white_count_d = white_count_q + white_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            white_count_q <= '0;
        end else begin
            white_count_q <= white_count_d;
        end
    end

    assign white_count = white_count_q;
`else
    logic unused_white;
    assign unused_white = ^lane_white;
`endif

endmodule

// File: tb/tb_stream_threshold_engine.sv
module tb_stream_threshold_engine;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int L  = 2;
    localparam int DW = 8;
    localparam int SD = 3;
    localparam int HD = 2;
    localparam int PW = L * DW;
    localparam int BEATS = (W / L) * H;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [DW-1:0]     threshold = '0;
    logic [1:0]        mode = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [L*3*DW-1:0] in_data = '0;
    logic [PW-1:0]     data_Red, data_Green, data_Blue;
    logic              out_valid, vertical_Pulse, horizontal_Pulse, busy, sig_done;
`ifdef STREAM_THRESHOLD_STATS_EN
    logic [$clog2(W*H+1)-1:0] white_count;
`endif

    always #5 clk = ~clk;

    stream_threshold_engine #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .LANES        (L),
        .DATA_WIDTH   (DW),
        .START_DELAY  (SD),
        .HSYNC_DELAY  (HD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .threshold        (threshold),
        .mode             (mode),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .data_Red         (data_Red),
        .data_Green       (data_Green),
        .data_Blue        (data_Blue),
        .out_valid        (out_valid),
        .vertical_Pulse   (vertical_Pulse),
        .horizontal_Pulse (horizontal_Pulse),
        .busy             (busy),
        .sig_done         (sig_done)
`ifdef STREAM_THRESHOLD_STATS_EN
        ,
        .white_count      (white_count)
`endif
    );

    typedef struct packed {
        logic [PW-1:0] r;
        logic [PW-1:0] g;
        logic [PW-1:0] b;
    } beat_t;

    // One table row = one whole frame of identical pixels.
    typedef struct packed {
        logic [1:0]  m;
        logic [7:0]  thr;
        logic [23:0] l0;
        logic [23:0] l1;
        logic [23:0] e0;
        logic [23:0] e1;
        logic [7:0]  nwhite;
    } vec_t;

    beat_t        sb_q[$];
    beat_t        cur_exp;
    beat_t        last_out;
    logic [47:0]  frame_px[BEATS];
    beat_t        frame_exp[BEATS];
    bit           vpat[4];
    int           vpat_len;
    vec_t         vecs[8];

    int n_checks = 0;
    int n_fail   = 0;

    // Per-frame observations
    int cyc = 0;
    int vcnt, out_cnt, done_cnt, hrun_len, row_beats, last_acc_cyc, done_cyc;
    int hruns[$];
    int rows[$];

    function automatic logic [23:0] px(input int r, input int g, input int b);
        return {8'(b), 8'(g), 8'(r)};
    endfunction

    function automatic beat_t mk_beat(input logic [23:0] e0, input logic [23:0] e1);
        beat_t t;
        t.r = {e1[7:0],   e0[7:0]};
        t.g = {e1[15:8],  e0[15:8]};
        t.b = {e1[23:16], e0[23:16]};
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: push the expected result of an accepted beat, advance, then
    // compare whatever the DUT shows after the edge.
    task automatic step();
        bit    acc;
        bit    hs;
        beat_t e;
        acc = in_valid && in_ready && !reset;
        if (acc) begin
            sb_q.push_back(cur_exp);
            last_acc_cyc = cyc;
            row_beats++;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("out_valid_latency", out_valid, acc);
        check("hpulse_eq_valid", horizontal_Pulse, out_valid);
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("beat_data", {data_Red, data_Green, data_Blue}, e);
                last_out = e;
            end
        end else begin
            check("hold_data", {data_Red, data_Green, data_Blue}, last_out);
        end
        if (vertical_Pulse) vcnt++;
        if (out_valid) out_cnt++;
        if (sig_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        hs = busy && !vertical_Pulse && !in_ready && !sig_done;
        if (hs) hrun_len++;
        else if (hrun_len > 0) begin
            hruns.push_back(hrun_len);
            hrun_len = 0;
        end
        if (!in_ready && row_beats > 0) begin
            rows.push_back(row_beats);
            row_beats = 0;
        end
    endtask

    task automatic clear_stats();
        vcnt = 0; out_cnt = 0; done_cnt = 0; hrun_len = 0; row_beats = 0;
        last_acc_cyc = -10; done_cyc = -1;
        hruns.delete();
        rows.delete();
    endtask

    task automatic fill_const(input vec_t v);
        for (int i = 0; i < BEATS; i++) begin
            frame_px[i]  = {v.l1, v.l0};
            frame_exp[i] = mk_beat(v.e0, v.e1);
        end
    endtask

    // Runs one complete frame; mid_beat >= 0 pulses start (with a different
    // threshold and mode) while that beat is being offered.
    task automatic do_frame(input string name, input logic [1:0] m, input logic [7:0] thr,
                            input int exp_white, input int mid_beat);
        int beat;
        int pidx;
        int guard;
        bit seen_done;
        bit acc_now;
        beat = 0; pidx = 0; guard = 0; seen_done = 0;
        clear_stats();
        mode = m; threshold = thr; start = 1'b1; in_valid = 1'b1;
        in_data = frame_px[0]; cur_exp = frame_exp[0];
        step();
        start = 1'b0;
        check("vsync_entered", vertical_Pulse, 1);
        while (!seen_done && guard < 300) begin
            start = 1'b0;
            if (in_ready && beat == mid_beat) begin
                start = 1'b1; threshold = 8'd50; mode = 2'd1;
            end
            in_valid = in_ready ? vpat[pidx % vpat_len] : 1'b1;
            if (in_ready) pidx++;
            in_data = frame_px[(beat < BEATS) ? beat : BEATS-1];
            cur_exp = frame_exp[(beat < BEATS) ? beat : BEATS-1];
            acc_now = in_valid && in_ready;
            step();
            if (acc_now) beat++;
            if (sig_done) begin
                seen_done = 1;
`ifdef STREAM_THRESHOLD_STATS_EN
                check("white_count", white_count, exp_white);
`endif
            end
            guard++;
        end
        check("frame_done_seen", seen_done, 1);
        start = 1'b0; in_valid = 1'b0;
        step();
        check("busy_after_done", busy, 0);
        check("done_one_cycle", sig_done, 0);
        check("vsync_cycles", vcnt, SD);
        check("hsync_rows", hruns.size(), H);
        for (int i = 0; i < hruns.size(); i++) check("hsync_cycles", hruns[i], HD);
        check("row_count", rows.size(), H);
        for (int i = 0; i < rows.size(); i++) check("beats_per_row", rows[i], W / L);
        check("frame_beats", out_cnt, BEATS);
        check("accepted_beats", beat, BEATS);
        check("done_pulses", done_cnt, 1);
        check("done_after_last_beat", done_cyc, last_acc_cyc + 1);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("frame %s: mode %0d thr %0d, %0d beats out, sig_done at cycle %0d (white %0d)",
                 name, m, thr, out_cnt, done_cyc, exp_white);
    endtask

    initial begin
        int guard;
        int beat;
        logic [7:0] r;

        vecs[0] = '{2'd0, 8'd90,  px(91,91,91),    px(90,90,90),    px(255,255,255), px(0,0,0),       8'd1};
        vecs[1] = '{2'd1, 8'd90,  px(91,91,91),    px(90,90,90),    px(0,0,0),       px(255,255,255), 8'd1};
        vecs[2] = '{2'd2, 8'd0,   px(255,255,254), px(0,0,1),       px(254,254,254), px(0,0,0),       8'd1};
        vecs[3] = '{2'd3, 8'd0,   px(1,2,3),       px(200,100,50),  px(1,2,3),       px(200,100,50),  8'd2};
        vecs[4] = '{2'd0, 8'd254, px(255,255,255), px(255,255,254), px(255,255,255), px(0,0,0),       8'd1};
        vecs[5] = '{2'd2, 8'd100, px(255,255,255), px(10,20,31),    px(255,255,255), px(20,20,20),    8'd1};
        vecs[6] = '{2'd1, 8'd0,   px(0,0,0),       px(1,1,1),       px(255,255,255), px(0,0,0),       8'd1};
        vecs[7] = '{2'd0, 8'd90,  px(100,100,100), px(100,100,100), px(255,255,255), px(255,255,255), 8'd2};

        last_out = '0;
        vpat[0] = 1; vpat[1] = 1; vpat[2] = 1; vpat[3] = 1; vpat_len = 4;

        // Reset state
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_vpulse", vertical_Pulse, 0);
        check("rst_hpulse", horizontal_Pulse, 0);
        check("rst_sig_done", sig_done, 0);
        check("rst_data", {data_Red, data_Green, data_Blue}, 0);
`ifdef STREAM_THRESHOLD_STATS_EN
        check("rst_white_count", white_count, 0);
`endif
        reset = 1'b0;
        step();

        // Table-driven frames, in_valid held high throughout
        for (int i = 0; i < 8; i++) begin
            fill_const(vecs[i]);
            do_frame($sformatf("vec%0d", i), vecs[i].m, vecs[i].thr,
                     int'(vecs[i].nwhite) * BEATS, -1);
        end

        // Stall: distinct pixels per beat in RGB pass-through, valid 1,0,0,1
        for (int i = 0; i < BEATS; i++) begin
            r = 8'(2*i + 1);
            frame_px[i]  = {px(r+1, r+17, r+33), px(r, r+16, r+32)};
            frame_exp[i] = mk_beat(px(r, r+16, r+32), px(r+1, r+17, r+33));
        end
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1;
        do_frame("stall", 2'd3, 8'd0, 2 * BEATS, -1);
        vpat[1] = 1; vpat[2] = 1;

        // Start pulsed mid-frame with another threshold/mode must be ignored
        fill_const('{2'd0, 8'd90, px(100,100,100), px(80,80,80),
                     px(255,255,255), px(0,0,0), 8'd1});
        do_frame("midstart", 2'd0, 8'd90, BEATS, 2);

        // Reset in the middle of a row
        clear_stats();
        fill_const(vecs[3]);
        mode = 2'd3; threshold = 8'd0; start = 1'b1; in_valid = 1'b1;
        in_data = frame_px[0]; cur_exp = frame_exp[0];
        step();
        start = 1'b0;
        guard = 0; beat = 0;
        while (beat < 2 && guard < 50) begin
            if (in_valid && in_ready) beat++;
            step();
            guard++;
        end
        check("reset_test_reached_data", beat, 2);
        in_valid = 1'b0;
        reset = 1'b1;
        last_out = '0;
        step();
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_data", {data_Red, data_Green, data_Blue}, 0);
        check("midrst_sig_done", sig_done, 0);
        repeat (30) step();
        check("midrst_no_done", done_cnt, 0);
        check("midrst_stays_idle", busy, 0);
        $display("frame reset_mid_row: reset after %0d beats, sig_done pulses %0d", beat, done_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
